// File: rtl/can_err_pkg.sv
// can_err_pkg: shared types and defaults for the CAN error manager.
// Holds the error-frame FSM states, error codes, fault-confinement encodings,
// frame timing defaults and the fault-confinement state derivation.
// Optional feature macro used by this slice: CAN_BUSOFF_RECOVERY_EN.
package can_err_pkg;

   localparam int FLAG_LEN_DEF   = 6;
   localparam int DELIM_LEN_DEF  = 8;
   localparam int PASSIVE_TH_DEF = 128;
   localparam int BUSOFF_TH_DEF  = 256;

   // Bus-off recovery: 128 runs of 11 consecutive recessive bits
   localparam int RECOVERY_RUN  = 11;
   localparam int RECOVERY_SEQS = 128;

   typedef enum logic [1:0] {
      IDLE,
      FLAG,
      WAIT_DELIM,
      DELIM
   } errFsm_t;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_BIT   = 3'd1;
   localparam logic [2:0] ERR_STUFF = 3'd2;
   localparam logic [2:0] ERR_FORM  = 3'd3;
   localparam logic [2:0] ERR_ACK   = 3'd4;
   localparam logic [2:0] ERR_CRC   = 3'd5;
   localparam logic [2:0] ERR_EOF   = 3'd6;

   localparam logic [1:0] ST_ACTIVE  = 2'd0;
   localparam logic [1:0] ST_PASSIVE = 2'd1;
   localparam logic [1:0] ST_BUSOFF  = 2'd2;

   // Fault-confinement state from the counter values; bus-off dominates passive
   function automatic logic [1:0] calcErrState(input logic [8:0] tec,
                                               input logic [7:0] rec,
                                               input int passiveTh,
                                               input int busoffTh);
      if (int'(tec) >= busoffTh) begin
         return ST_BUSOFF;
      end else if ((int'(tec) >= passiveTh) || (int'(rec) >= passiveTh)) begin
         return ST_PASSIVE;
      end
      return ST_ACTIVE;
   endfunction

endpackage

// File: rtl/can_err_counters.sv
// can_err_counters: TEC/REC arithmetic with saturation, registered
// fault-confinement state, and (with CAN_BUSOFF_RECOVERY_EN defined) the
// bus-off recovery sequence counter. Without the macro bus-off holds until reset.
module can_err_counters
   import can_err_pkg::*;
#(
   parameter int PASSIVE_TH = PASSIVE_TH_DEF,
   parameter int BUSOFF_TH  = BUSOFF_TH_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sp_i,
   input  logic       rx_i,
   input  logic       errEvent_i,
   input  logic       isTx_i,
   input  logic       txOk_i,
   input  logic       rxOk_i,
   output logic [8:0] tec_o,
   output logic [7:0] rec_o,
   output logic [1:0] errState_o,
   output logic [1:0] errStateNext_o
);

   logic [8:0] tec_q, tec_d;
   logic [7:0] rec_q, rec_d;
   logic [1:0] errState_q;
   logic       recover;

`ifdef CAN_BUSOFF_RECOVERY_EN
   logic [3:0] runCnt_q, runCnt_d;
   logic [6:0] seqCnt_q, seqCnt_d;

   // Count runs of recessive bits while bus-off; a dominant bit restarts the run
   always_comb begin
      runCnt_d = runCnt_q;
      seqCnt_d = seqCnt_q;
      recover  = 1'b0;
      if (errState_q != ST_BUSOFF) begin
         runCnt_d = 4'd0;
         seqCnt_d = 7'd0;
      end else if (!rx_i) begin
         runCnt_d = 4'd0;
      end else if (runCnt_q == 4'(RECOVERY_RUN - 1)) begin
         runCnt_d = 4'd0;
         if (seqCnt_q == 7'(RECOVERY_SEQS - 1)) begin
            seqCnt_d = 7'd0;
            recover  = 1'b1;
         end else begin
            seqCnt_d = seqCnt_q + 7'd1;
         end
      end else begin
         runCnt_d = runCnt_q + 4'd1;
      end
   end

   // Recovery counters advance once per bit time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         runCnt_q <= 4'd0;
         seqCnt_q <= 7'd0;
      end else if (sp_i) begin
         runCnt_q <= runCnt_d;
         seqCnt_q <= seqCnt_d;
      end
   end
`else
   logic unusedRx;
   assign unusedRx = rx_i;
   assign recover  = 1'b0;
`endif

   // Counter update: an error beats a same-bit success, bus-off freezes both
   always_comb begin
      tec_d = tec_q;
      rec_d = rec_q;
      if (errState_q == ST_BUSOFF) begin
         if (recover) begin
            tec_d = 9'd0;
            rec_d = 8'd0;
         end
      end else if (errEvent_i) begin
         if (isTx_i) begin
            tec_d = (tec_q >= 9'd248) ? 9'd256 : tec_q + 9'd8;
         end else begin
            rec_d = (rec_q == 8'hFF) ? 8'hFF : rec_q + 8'd1;
         end
      end else begin
         if (txOk_i && (tec_q != 9'd0)) begin
            tec_d = tec_q - 9'd1;
         end
         if (rxOk_i) begin
            if (rec_q > 8'd127) begin
               rec_d = 8'd120;
            end else if (rec_q != 8'd0) begin
               rec_d = rec_q - 8'd1;
            end
         end
      end
   end

   assign errStateNext_o = calcErrState(tec_d, rec_d, PASSIVE_TH, BUSOFF_TH);

   // Counters and confinement state register together on the sample point
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tec_q      <= 9'd0;
         rec_q      <= 8'd0;
         errState_q <= ST_ACTIVE;
      end else if (sp_i) begin
         tec_q      <= tec_d;
         rec_q      <= rec_d;
         errState_q <= errStateNext_o;
      end
   end

   assign tec_o      = tec_q;
   assign rec_o      = rec_q;
   assign errState_o = errState_q;

endmodule

// File: rtl/can_error_manager.sv
// can_error_manager: fixed-priority error selection, error frame sequencing
// (flag then recessive delimiter) and fault confinement via can_err_counters.
// Optional feature macro: CAN_BUSOFF_RECOVERY_EN (bus-off recovery, in the counters).
module can_error_manager
   import can_err_pkg::*;
#(
   parameter int FLAG_LEN   = FLAG_LEN_DEF,
   parameter int DELIM_LEN  = DELIM_LEN_DEF,
   parameter int PASSIVE_TH = PASSIVE_TH_DEF,
   parameter int BUSOFF_TH  = BUSOFF_TH_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sp,
   input  logic       rx,
   input  logic       bit_err_n,
   input  logic       stuff_err_n,
   input  logic       form_err_n,
   input  logic       ack_err_n,
   input  logic       crc_err_n,
   input  logic       eof_err_n,
   input  logic       is_tx,
   input  logic       tx_ok,
   input  logic       rx_ok,
   output logic       tx_drive,
   output logic       err_frame,
   output logic [2:0] err_code,
   output logic [8:0] tec,
   output logic [7:0] rec,
   output logic [1:0] err_state
);

   errFsm_t    state_q;
   logic [3:0] bitCnt_q;
   logic       txDrive_q;
   logic       errFrame_q;
   logic [2:0] errCode_q;
   logic [2:0] winCode;
   logic [2:0] eventCode;
   logic       errEvent;
   logic [1:0] errStateNext;
   logic       flagLevel;

   // Fixed priority: bit > stuff > form > ack > crc > eof
   always_comb begin
      winCode = ERR_NONE;
      if (!bit_err_n) begin
         winCode = ERR_BIT;
      end else if (!stuff_err_n) begin
         winCode = ERR_STUFF;
      end else if (!form_err_n) begin
         winCode = ERR_FORM;
      end else if (!ack_err_n) begin
         winCode = ERR_ACK;
      end else if (!crc_err_n) begin
         winCode = ERR_CRC;
      end else if (!eof_err_n) begin
         winCode = ERR_EOF;
      end
   end

   // Errors are accepted only in IDLE, plus a dominant bit inside the delimiter
   always_comb begin
      errEvent  = 1'b0;
      eventCode = winCode;
      if (err_state != ST_BUSOFF) begin
         if ((state_q == IDLE) && (winCode != ERR_NONE)) begin
            errEvent = 1'b1;
         end else if ((state_q == DELIM) && !rx) begin
            errEvent  = 1'b1;
            eventCode = ERR_FORM;
         end
      end
   end

   can_err_counters #(
      .PASSIVE_TH (PASSIVE_TH),
      .BUSOFF_TH  (BUSOFF_TH)
   ) uCounters (
      .clk            (clk),
      .reset          (reset),
      .sp_i           (sp),
      .rx_i           (rx),
      .errEvent_i     (errEvent),
      .isTx_i         (is_tx),
      .txOk_i         (tx_ok),
      .rxOk_i         (rx_ok),
      .tec_o          (tec),
      .rec_o          (rec),
      .errState_o     (err_state),
      .errStateNext_o (errStateNext)
   );

   // Flag polarity follows the confinement state the counters are moving to,
   // so a flag raised by the error that crosses into passive is already passive
   assign flagLevel = (errStateNext == ST_ACTIVE) ? 1'b0 : 1'b1;

   // Error frame sequencer with registered bus-facing outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bitCnt_q   <= 4'd0;
         txDrive_q  <= 1'b1;
         errFrame_q <= 1'b0;
         errCode_q  <= ERR_NONE;
      end else if (sp) begin
         if (errStateNext == ST_BUSOFF) begin
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            txDrive_q  <= 1'b1;
            errFrame_q <= 1'b0;
            if (errEvent) begin
               errCode_q <= eventCode;
            end
         end else if (errEvent) begin
            state_q    <= FLAG;
            bitCnt_q   <= 4'd0;
            txDrive_q  <= flagLevel;
            errFrame_q <= 1'b1;
            errCode_q  <= eventCode;
         end else begin
            case (state_q)
               IDLE: begin
                  txDrive_q <= 1'b1;
               end
               FLAG: begin
                  if (bitCnt_q == 4'(FLAG_LEN - 1)) begin
                     state_q   <= WAIT_DELIM;
                     bitCnt_q  <= 4'd0;
                     txDrive_q <= 1'b1;
                  end else begin
                     bitCnt_q  <= bitCnt_q + 4'd1;
                     txDrive_q <= flagLevel;
                  end
               end
               WAIT_DELIM: begin
                  txDrive_q <= 1'b1;
                  if (rx) begin
                     state_q  <= DELIM;
                     bitCnt_q <= 4'd1;
                  end
               end
               DELIM: begin
                  txDrive_q <= 1'b1;
                  if (bitCnt_q == 4'(DELIM_LEN - 1)) begin
                     state_q    <= IDLE;
                     bitCnt_q   <= 4'd0;
                     errFrame_q <= 1'b0;
                  end else begin
                     bitCnt_q <= bitCnt_q + 4'd1;
                  end
               end
               default: begin
                  state_q    <= IDLE;
                  bitCnt_q   <= 4'd0;
                  txDrive_q  <= 1'b1;
                  errFrame_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tx_drive  = txDrive_q;
   assign err_frame = errFrame_q;
   assign err_code  = errCode_q;

endmodule

// File: tb/tb_can_error_manager.sv
// tb_can_error_manager: directed bench for can_error_manager. Stimulus pushes
// the expected post-sample-point outputs into a queue; monitors pop and compare
// after every sample point and after every reset assertion.
module tb_can_error_manager;

   typedef struct {
      string      name;
      logic [5:0] care;
      logic       txd;
      logic       ef;
      logic [2:0] code;
      logic [8:0] tec;
      logic [7:0] rec;
      logic [1:0] st;
   } exp_t;

   localparam logic [5:0] ALL  = 6'h3F;
   localparam logic [5:0] NOTX = 6'h3E;
   localparam logic [5:0] CNTS = 6'h38;
   localparam logic [5:0] NONE = 6'h3F;
   localparam logic [5:0] EBIT = 6'b011111;
   localparam logic [5:0] ESTF = 6'b101111;
   localparam logic [5:0] EACK = 6'b111011;
   localparam logic [5:0] ECRC = 6'b111101;

   logic       clk;
   logic       reset;
   logic       sp;
   logic       rx;
   logic [5:0] errN;
   logic       isTx;
   logic       txOk;
   logic       rxOk;
   logic       tx_drive;
   logic       err_frame;
   logic [2:0] err_code;
   logic [8:0] tec;
   logic [7:0] rec;
   logic [1:0] err_state;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   can_error_manager dut (
      .clk         (clk),
      .reset       (reset),
      .sp          (sp),
      .rx          (rx),
      .bit_err_n   (errN[5]),
      .stuff_err_n (errN[4]),
      .form_err_n  (errN[3]),
      .ack_err_n   (errN[2]),
      .crc_err_n   (errN[1]),
      .eof_err_n   (errN[0]),
      .is_tx       (isTx),
      .tx_ok       (txOk),
      .rx_ok       (rxOk),
      .tx_drive    (tx_drive),
      .err_frame   (err_frame),
      .err_code    (err_code),
      .tec         (tec),
      .rec         (rec),
      .err_state   (err_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pushExp(input string nm, input logic [5:0] care, input logic txd,
                          input logic ef, input logic [2:0] code, input logic [8:0] t,
                          input logic [7:0] r, input logic [1:0] s);
      exp_t e;
      e.name = nm; e.care = care; e.txd = txd; e.ef = ef;
      e.code = code; e.tec = t; e.rec = r; e.st = s;
      expQ.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_output: no expectation queued at %0t", $time);
         return;
      end
      e = expQ.pop_front();
      if (e.care[0]) begin
         checks++;
         if (tx_drive !== e.txd) begin
            errors++;
            $display("[TB] FAIL %s tx_drive got %0b want %0b", e.name, tx_drive, e.txd);
         end
      end
      if (e.care[1]) begin
         checks++;
         if (err_frame !== e.ef) begin
            errors++;
            $display("[TB] FAIL %s err_frame got %0b want %0b", e.name, err_frame, e.ef);
         end
      end
      if (e.care[2]) begin
         checks++;
         if (err_code !== e.code) begin
            errors++;
            $display("[TB] FAIL %s err_code got %0d want %0d", e.name, err_code, e.code);
         end
      end
      if (e.care[3]) begin
         checks++;
         if (tec !== e.tec) begin
            errors++;
            $display("[TB] FAIL %s tec got %0d want %0d", e.name, tec, e.tec);
         end
      end
      if (e.care[4]) begin
         checks++;
         if (rec !== e.rec) begin
            errors++;
            $display("[TB] FAIL %s rec got %0d want %0d", e.name, rec, e.rec);
         end
      end
      if (e.care[5]) begin
         checks++;
         if (err_state !== e.st) begin
            errors++;
            $display("[TB] FAIL %s err_state got %0d want %0d", e.name, err_state, e.st);
         end
      end
   endtask

   // One bit time: sample point on one clk, then an idle clk with sp low
   task automatic applyStimulus(input logic [5:0] eN, input logic rxv, input logic tx,
                                input logic okT, input logic okR, input string nm,
                                input logic [5:0] care, input logic txd, input logic ef,
                                input logic [2:0] code, input logic [8:0] t,
                                input logic [7:0] r, input logic [1:0] s);
      errN = eN; rx = rxv; isTx = tx; txOk = okT; rxOk = okR; sp = 1'b1;
      pushExp(nm, care, txd, ef, code, t, r, s);
      @(negedge clk);
      sp = 1'b0; errN = NONE; txOk = 1'b0; rxOk = 1'b0;
      @(negedge clk);
   endtask

   // Error bit, five more flag bits (one with an ignored error), then the flag end
   task automatic flagPhase(input logic [5:0] eN, input logic rxv, input logic tx,
                            input logic okT, input logic okR, input string nm,
                            input logic [5:0] care0, input logic lvl, input logic [2:0] code,
                            input logic [8:0] t, input logic [7:0] r, input logic [1:0] s);
      applyStimulus(eN, rxv, tx, okT, okR, {nm, "_start"}, care0, lvl, 1'b1, code, t, r, s);
      for (int i = 1; i < 6; i++) begin
         applyStimulus((i == 2) ? EBIT : NONE, lvl, tx, 1'b0, 1'b0, {nm, "_flag"},
                       care0, lvl, 1'b1, code, t, r, s);
      end
      applyStimulus(NONE, 1'b1, tx, 1'b0, 1'b0, {nm, "_flag_end"}, ALL, 1'b1, 1'b1,
                    code, t, r, s);
   endtask

   // Optional dominant bits while waiting, then eight recessive delimiter bits
   task automatic delimPhase(input string nm, input int waitDom, input logic [2:0] code,
                             input logic [8:0] t, input logic [7:0] r, input logic [1:0] s);
      for (int w = 0; w < waitDom; w++) begin
         applyStimulus(NONE, 1'b0, 1'b0, 1'b0, 1'b0, {nm, "_wait"}, ALL, 1'b1, 1'b1,
                       code, t, r, s);
      end
      for (int d = 1; d < 8; d++) begin
         applyStimulus((d == 4) ? ESTF : NONE, 1'b1, 1'b0, 1'b0, 1'b0, {nm, "_delim"},
                       ALL, 1'b1, 1'b1, code, t, r, s);
      end
      applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b0, {nm, "_delim_end"}, ALL, 1'b1, 1'b0,
                    code, t, r, s);
   endtask

   // Compare after every sample-point edge, away from the edge itself
   always begin
      @(posedge clk);
      if (sp === 1'b1) begin
         #2;
         checkOutput();
      end
   end

   // Compare shortly after reset rises, before any further clock edge
   always begin
      @(posedge reset);
      #1;
      checkOutput();
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      sp = 1'b0; rx = 1'b1; errN = NONE; isTx = 1'b0; txOk = 1'b0; rxOk = 1'b0;
      reset = 1'b0;
      #2;
      pushExp("reset_init", ALL, 1'b1, 1'b0, 3'd0, 9'd0, 8'd0, 2'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // CRC error as receiver: 6 dominant flag bits, 8 recessive delimiter bits
      flagPhase(ECRC, 1'b1, 1'b0, 1'b0, 1'b0, "crc_rx", ALL, 1'b0, 3'd5, 9'd0, 8'd1, 2'd0);
      delimPhase("crc_rx", 0, 3'd5, 9'd0, 8'd1, 2'd0);

      // Bit and EOF together as transmitter: bit wins, one frame, waits on dominant bus
      flagPhase(6'b011110, 1'b1, 1'b1, 1'b0, 1'b0, "bit_eof_tx", ALL, 1'b0, 3'd1, 9'd8, 8'd1, 2'd0);
      delimPhase("bit_eof_tx", 2, 3'd1, 9'd8, 8'd1, 2'd0);

      // Successful frames decrement both counters, rec stops at zero
      applyStimulus(NONE, 1'b1, 1'b0, 1'b1, 1'b1, "ok_both", ALL, 1'b1, 1'b0, 3'd1, 9'd7, 8'd0, 2'd0);
      applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b1, "rx_ok_zero", ALL, 1'b1, 1'b0, 3'd1, 9'd7, 8'd0, 2'd0);

      // Receiver error with a same-bit tx_ok: the ok is dropped, tec stays 7
      flagPhase(ESTF, 1'b1, 1'b0, 1'b1, 1'b0, "stuff_ok_drop", ALL, 1'b0, 3'd2, 9'd7, 8'd1, 2'd0);
      delimPhase("stuff_ok_drop", 0, 3'd2, 9'd7, 8'd1, 2'd0);

      // ACK error, then a dominant 3rd delimiter bit restarts the flag as a form error
      flagPhase(EACK, 1'b1, 1'b1, 1'b0, 1'b0, "ack_tx", ALL, 1'b0, 3'd4, 9'd15, 8'd1, 2'd0);
      applyStimulus(NONE, 1'b1, 1'b1, 1'b0, 1'b0, "form_d1", ALL, 1'b1, 1'b1, 3'd4, 9'd15, 8'd1, 2'd0);
      applyStimulus(NONE, 1'b1, 1'b1, 1'b0, 1'b0, "form_d2", ALL, 1'b1, 1'b1, 3'd4, 9'd15, 8'd1, 2'd0);
      flagPhase(NONE, 1'b0, 1'b1, 1'b0, 1'b0, "form_err", ALL, 1'b0, 3'd3, 9'd23, 8'd1, 2'd0);
      delimPhase("form_err", 0, 3'd3, 9'd23, 8'd1, 2'd0);

      // Reset in the middle of a flag clears everything without a clock edge
      applyStimulus(ECRC, 1'b1, 1'b0, 1'b0, 1'b0, "pre_reset", ALL, 1'b0, 1'b1, 3'd5, 9'd23, 8'd2, 2'd0);
      applyStimulus(NONE, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset_flag", ALL, 1'b0, 1'b1, 3'd5, 9'd23, 8'd2, 2'd0);
      @(posedge clk);
      #2;
      pushExp("reset_mid_flag", ALL, 1'b1, 1'b0, 3'd0, 9'd0, 8'd0, 2'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 128 receiver errors reach passive; rx_ok above 127 drops rec to 120
      for (int i = 1; i <= 128; i++) begin
         flagPhase(ECRC, 1'b1, 1'b0, 1'b0, 1'b0, "rec_loop", (i == 128) ? NOTX : ALL, 1'b0,
                   3'd5, 9'd0, 8'(i), (i == 128) ? 2'd1 : 2'd0);
         delimPhase("rec_loop", 0, 3'd5, 9'd0, 8'(i), (i == 128) ? 2'd1 : 2'd0);
      end
      applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b1, "rec_drop", ALL, 1'b1, 1'b0, 3'd5, 9'd0, 8'd120, 2'd0);

      // Transmitter errors: passive at 128, passive flags are recessive
      for (int i = 1; i <= 31; i++) begin
         flagPhase(EBIT, 1'b1, 1'b1, 1'b0, 1'b0, "tec_loop", (i == 16) ? NOTX : ALL,
                   (i >= 17) ? 1'b1 : 1'b0, 3'd1, 9'(8 * i), 8'd120, (i >= 16) ? 2'd1 : 2'd0);
         delimPhase("tec_loop", 0, 3'd1, 9'(8 * i), 8'd120, (i >= 16) ? 2'd1 : 2'd0);
      end

      // 32nd transmitter error saturates tec at 256 and enters bus-off
      applyStimulus(EBIT, 1'b1, 1'b1, 1'b0, 1'b0, "busoff_enter", CNTS, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
      applyStimulus(ESTF, 1'b1, 1'b1, 1'b1, 1'b1, "busoff_ignore", ALL, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
      applyStimulus(NONE, 1'b0, 1'b0, 1'b0, 1'b0, "busoff_dom", ALL, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);

      for (int k = 1; k <= 1408; k++) begin
`ifdef CAN_BUSOFF_RECOVERY_EN
         if (k == 1407) begin
            applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b0, "recovery_almost", ALL, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
         end else if (k == 1408) begin
            applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b0, "recovery_done", ALL, 1'b1, 1'b0, 3'd1, 9'd0, 8'd0, 2'd0);
         end else begin
            applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b0, "recovery_run", 6'd0, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
         end
`else
         applyStimulus(NONE, 1'b1, 1'b0, 1'b0, 1'b0, "busoff_run", (k == 1408) ? ALL : 6'd0,
                       1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
`endif
      end

`ifdef CAN_BUSOFF_RECOVERY_EN
      flagPhase(EBIT, 1'b1, 1'b1, 1'b0, 1'b0, "after_recovery", ALL, 1'b0, 3'd1, 9'd8, 8'd0, 2'd0);
      delimPhase("after_recovery", 0, 3'd1, 9'd8, 8'd0, 2'd0);
`else
      applyStimulus(EBIT, 1'b1, 1'b1, 1'b0, 1'b0, "busoff_hold", ALL, 1'b1, 1'b0, 3'd1, 9'd256, 8'd120, 2'd2);
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftover_expectations got %0d want 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
